// File: rtl/fd_pkg.sv
// Shared types and constants for the FAST9 fetch controller.
package fd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        PRESENT,
        DONE
    } fetchState_t;

    // Register-file write select meaning "no write this cycle"
    localparam logic [4:0] REG_NONE = 5'd31;

    // Reads per centre: the centre itself plus 16 circle points
    localparam int N_PTS = 17;

    // Radius-3 Bresenham circle, entry i is read index k = i + 1
    localparam int CIRCLE_DX [16] = '{ 0,  1,  2,  3,  3,  3,  2,  1,
                                       0, -1, -2, -3, -3, -3, -2, -1};
    localparam int CIRCLE_DY [16] = '{-3, -3, -2, -1,  0,  1,  2,  3,
                                       3,  3,  2,  1,  0, -1, -2, -3};

endpackage

// File: rtl/fd_fetch_if.sv
// Bus between the fetch controller and its surroundings: SRAM read port,
// register-file steering, datapath handshake and frame control.
interface fd_fetch_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic [ADDR_W-1:0] sramAddr;
    logic              sramRe;
    logic [4:0]        regAddr;
    logic              readen;
    logic [7:0]        curX;
    logic [7:0]        curY;
    logic              dpAck;
    logic              busy;
    logic              done;

    modport master (
        input  start, dpAck,
        output sramAddr, sramRe, regAddr, readen, curX, curY, busy, done
    );

    modport slave (
        output start, dpAck,
        input  sramAddr, sramRe, regAddr, readen, curX, curY, busy, done
    );
endinterface

// File: rtl/fd_circle_offset.sv
// Combinational read index -> signed (dx,dy) offset lookup.
// Index 0 is the centre; anything past the last circle point maps to (0,0).
module fd_circle_offset
    import fd_pkg::*;
(
    input  logic [4:0]        kIdx_i,
    output logic signed [2:0] dx_o,
    output logic signed [2:0] dy_o
);

    // Table lookup with the centre and out-of-range indices at zero offset
    always_comb begin
        dx_o = 3'sd0;
        dy_o = 3'sd0;
        if (kIdx_i != 5'd0 && kIdx_i < 5'(N_PTS)) begin
            dx_o = 3'(CIRCLE_DX[4'(kIdx_i - 5'd1)]);
            dy_o = 3'(CIRCLE_DY[4'(kIdx_i - 5'd1)]);
        end
    end

endmodule

// File: rtl/fd_fetch.sv
// FAST9 fetch controller: scans centres raster-wise, issues the 17 SRAM
// reads per centre, steers returned bytes into the register file and
// presents the filled register file to the segment-test datapath.
module fd_fetch
    import fd_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic       clock,
    input  logic       nReset,
    fd_fetch_if.master bus
);

    localparam logic [7:0] X_FIRST = 8'd3;
    localparam logic [7:0] Y_FIRST = 8'd3;
    localparam logic [7:0] X_LAST  = 8'(IMG_W - 4);
    localparam logic [7:0] Y_LAST  = 8'(IMG_H - 4);

    fetchState_t       state_q;
    logic [4:0]        k_q;
    logic [7:0]        x_q;
    logic [7:0]        y_q;
    logic [ADDR_W-1:0] sramAddr_q;
    logic              sramRe_q;
    logic [4:0]        regAddr_q;
    logic              readen_q;
    logic [7:0]        curX_q;
    logic [7:0]        curY_q;
    logic              busy_q;
    logic              done_q;

    logic [7:0]        xNext_d;
    logic [7:0]        yNext_d;
    logic [4:0]        lookK_d;
    logic [7:0]        lookX_d;
    logic [7:0]        lookY_d;
    logic [ADDR_W-1:0] rowAddr_d;
    logic [ADDR_W-1:0] addr_d;
    logic signed [2:0] dx;
    logic signed [2:0] dy;
    logic              isLast;

    assign isLast = (x_q == X_LAST) && (y_q == Y_LAST);

    // Raster advance: x fastest, wrapping to the first column of the next row
    always_comb begin
        xNext_d = x_q + 8'd1;
        yNext_d = y_q;
        if (x_q == X_LAST) begin
            xNext_d = X_FIRST;
            yNext_d = y_q + 8'd1;
        end
    end

    // Pick which (k, x, y) the address adder works on for the read issued next
    always_comb begin
        lookK_d = k_q + 5'd1;
        lookX_d = x_q;
        lookY_d = y_q;
        case (state_q)
            IDLE: begin
                lookK_d = 5'd0;
                lookX_d = X_FIRST;
                lookY_d = Y_FIRST;
            end
            PRESENT: begin
                lookK_d = 5'd0;
                lookX_d = xNext_d;
                lookY_d = yNext_d;
            end
            default: ;
        endcase
    end

    fd_circle_offset uOffset (
        .kIdx_i (lookK_d),
        .dx_o   (dx),
        .dy_o   (dy)
    );

    // Linear SRAM address; signed offsets are sign-extended to the address width
    always_comb begin
        rowAddr_d = ADDR_W'(lookY_d) + ADDR_W'(dy);
        addr_d    = rowAddr_d * ADDR_W'(IMG_W) + ADDR_W'(lookX_d) + ADDR_W'(dx);
    end

    // Control FSM with all outputs registered alongside the state
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            k_q        <= 5'd0;
            x_q        <= 8'd0;
            y_q        <= 8'd0;
            sramAddr_q <= '0;
            sramRe_q   <= 1'b0;
            regAddr_q  <= REG_NONE;
            readen_q   <= 1'b0;
            curX_q     <= 8'd0;
            curY_q     <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= FETCH;
                        k_q        <= 5'd0;
                        x_q        <= X_FIRST;
                        y_q        <= Y_FIRST;
                        sramAddr_q <= addr_d;
                        sramRe_q   <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                FETCH: begin
                    regAddr_q <= k_q;
                    if (k_q == 5'(N_PTS - 1)) begin
                        sramRe_q <= 1'b0;
                        state_q  <= DRAIN;
                    end else begin
                        k_q        <= k_q + 5'd1;
                        sramAddr_q <= addr_d;
                    end
                end
                DRAIN: begin
                    regAddr_q <= REG_NONE;
                    readen_q  <= 1'b1;
                    curX_q    <= x_q;
                    curY_q    <= y_q;
                    state_q   <= PRESENT;
                end
                PRESENT: begin
                    if (bus.dpAck) begin
                        readen_q <= 1'b0;
                        if (isLast) begin
                            state_q <= DONE;
                        end else begin
                            x_q        <= xNext_d;
                            y_q        <= yNext_d;
                            k_q        <= 5'd0;
                            sramAddr_q <= addr_d;
                            sramRe_q   <= 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sramAddr = sramAddr_q;
    assign bus.sramRe   = sramRe_q;
    assign bus.regAddr  = regAddr_q;
    assign bus.readen   = readen_q;
    assign bus.curX     = curX_q;
    assign bus.curY     = curY_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_fd_fetch.sv
// Self-checking bench for fd_fetch on an 8x8 image against a scan-order model.
module tb_fd_fetch;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int ADDR_W = 12;
    localparam int NX     = IMG_W - 6;
    localparam int NY     = IMG_H - 6;
    localparam int NC     = NX * NY;

    logic clock = 1'b0;
    logic nReset;

    always #5 clock = ~clock;

    fd_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    fd_fetch #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock  (clock),
        .nReset (nReset),
        .bus    (bus)
    );

    // Circle offsets indexed by read number k (0 = centre)
    int dxTab [17] = '{0,  0,  1,  2,  3,  3,  3,  2,  1,  0, -1, -2, -3, -3, -3, -2, -1};
    int dyTab [17] = '{0, -3, -3, -2, -1,  0,  1,  2,  3,  3,  3,  2,  1,  0, -1, -2, -3};

    int testsRun    = 0;
    int testsFailed = 0;

    // Model: per scan, centre index and cycles elapsed within that centre
    bit mActive;
    bit mDoneStage;
    bit mDoneOut;
    bit mFresh;
    int mCentre;
    int mPhase;

    int windowCount;
    int doneCount;
    bit prevReaden;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int expAddr(input int c, input int k);
        int x;
        int y;
        x = 3 + c % NX;
        y = 3 + c / NX;
        return ((y + dyTab[k]) * IMG_W + x + dxTab[k]) % (1 << ADDR_W);
    endfunction

    task automatic modelReset();
        mActive    = 1'b0;
        mDoneStage = 1'b0;
        mDoneOut   = 1'b0;
        mFresh     = 1'b1;
        mCentre    = 0;
        mPhase     = 0;
    endtask

    // 17 read cycles, one drain cycle, then present until acknowledged
    task automatic modelEdge(input bit st, input bit ack);
        if (mDoneStage) begin
            mDoneStage = 1'b0;
            mDoneOut   = 1'b1;
        end else begin
            mDoneOut = 1'b0;
            if (!mActive) begin
                if (st) begin
                    mActive = 1'b1;
                    mCentre = 0;
                    mPhase  = 0;
                    mFresh  = 1'b0;
                end
            end else if (mPhase < 18) begin
                mPhase++;
            end else if (ack) begin
                if (mCentre == NC - 1) begin
                    mActive    = 1'b0;
                    mDoneStage = 1'b1;
                end else begin
                    mCentre++;
                    mPhase = 0;
                end
            end
        end
    endtask

    task automatic checkAll();
        bit expRe;
        bit expReaden;
        int expReg;
        expRe     = mActive && (mPhase <= 16);
        expReaden = mActive && (mPhase >= 18);
        expReg    = (mActive && mPhase >= 1 && mPhase <= 17) ? mPhase - 1 : 31;
        checkOutput("sramRe", {31'b0, bus.sramRe}, {31'b0, expRe});
        if (expRe)
            checkOutput("sramAddr", {20'b0, bus.sramAddr}, expAddr(mCentre, mPhase));
        checkOutput("regAddr", {27'b0, bus.regAddr}, expReg);
        checkOutput("readen", {31'b0, bus.readen}, {31'b0, expReaden});
        if (expReaden) begin
            checkOutput("curX", {24'b0, bus.curX}, 3 + mCentre % NX);
            checkOutput("curY", {24'b0, bus.curY}, 3 + mCentre / NX);
        end
        checkOutput("busy", {31'b0, bus.busy}, {31'b0, mActive || mDoneStage});
        checkOutput("done", {31'b0, bus.done}, {31'b0, mDoneOut});
        if (mFresh) begin
            checkOutput("rstSramAddr", {20'b0, bus.sramAddr}, 0);
            checkOutput("rstCurX", {24'b0, bus.curX}, 0);
            checkOutput("rstCurY", {24'b0, bus.curY}, 0);
        end
        if (bus.readen && !prevReaden) windowCount++;
        prevReaden = bus.readen;
        if (bus.done) doneCount++;
    endtask

    task automatic applyStimulus(input bit st, input bit ack);
        bus.start = st;
        bus.dpAck = ack;
        @(posedge clock);
        if (nReset) modelEdge(st, ack);
        #1;
        checkAll();
    endtask

    // Run until the model is back in idle; ackPct sets dpAck probability
    task automatic runToIdle(input int ackPct, input bit pokeStart);
        bit st;
        bit ack;
        for (int i = 0; i < 3000 && (mActive || mDoneStage); i++) begin
            st  = pokeStart && mActive && ($urandom_range(0, 99) < 25);
            ack = ($urandom_range(0, 99) < ackPct);
            applyStimulus(st, ack);
        end
        checkOutput("scanTimeout", {31'b0, mActive || mDoneStage}, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        int doneAt;
        bit ack;

        modelReset();
        prevReaden = 1'b0;
        nReset     = 1'b0;
        bus.start  = 1'b0;
        bus.dpAck  = 1'b0;
        #12;
        checkAll();
        nReset = 1'b1;
        applyStimulus(0, 0);

        // Back-to-back scan with dpAck tied high
        windowCount = 0;
        doneCount   = 0;
        doneAt      = 0;
        applyStimulus(1, 1);
        cnt = 1;
        for (int i = 0; i < 400 && doneAt == 0; i++) begin
            applyStimulus(0, 1);
            cnt++;
            if (bus.done) doneAt = cnt;
        end
        checkOutput("doneLatency", doneAt, 19 * NC + 2);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0);
        checkOutput("readenWindows", windowCount, NC);
        checkOutput("donePulses", doneCount, 1);

        // Long hold in PRESENT, then random acks with stray start pulses
        applyStimulus(1, 0);
        for (int i = 0; i < 40 && mPhase < 18; i++) applyStimulus(0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0);
            checkOutput("holdReaden", {31'b0, bus.readen}, 1);
            checkOutput("holdSramRe", {31'b0, bus.sramRe}, 0);
            checkOutput("holdRegAddr", {27'b0, bus.regAddr}, 31);
        end
        runToIdle(35, 1'b1);

        // Asynchronous reset while read k = 7 is on the bus
        applyStimulus(1, 0);
        for (int i = 0; i < 20 && mPhase < 7; i++) applyStimulus(0, 0);
        #2;
        nReset = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("midRstSramRe", {31'b0, bus.sramRe}, 0);
        applyStimulus(0, 0);
        applyStimulus(1, 1);
        #3;
        nReset = 1'b1;
        applyStimulus(0, 0);
        applyStimulus(1, 1);
        checkOutput("restartAddr", {20'b0, bus.sramAddr}, 3 * IMG_W + 3);
        runToIdle(100, 1'b0);

        // Last acknowledge together with start, start held into DONE
        applyStimulus(1, 0);
        for (int i = 0; i < 2000 && !(mCentre == NC - 1 && mPhase >= 18); i++) begin
            ack = ($urandom_range(0, 2) == 0);
            applyStimulus(0, ack);
        end
        applyStimulus(1, 1);
        checkOutput("doneStageBusy", {31'b0, bus.busy}, 1);
        applyStimulus(1, 0);
        checkOutput("doneSeen", {31'b0, bus.done}, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0);
        checkOutput("idleBusy", {31'b0, bus.busy}, 0);
        applyStimulus(1, 0);
        checkOutput("newScanAddr", {20'b0, bus.sramAddr}, 3 * IMG_W + 3);
        runToIdle(100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
